// File: rtl/usart_pkg.sv
// Shared USART definitions: FSM encoding, frame-format codes, sample points and the RX buffer entry.
package usart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [2:0] UCSZ_5 = 3'b000;
    localparam logic [2:0] UCSZ_6 = 3'b001;
    localparam logic [2:0] UCSZ_7 = 3'b010;
    localparam logic [2:0] UCSZ_8 = 3'b011;
    localparam logic [2:0] UCSZ_9 = 3'b111;

    localparam logic [1:0] UPM_NONE = 2'b00;
    localparam logic [1:0] UPM_EVEN = 2'b10;
    localparam logic [1:0] UPM_ODD  = 2'b11;

    // Tick numbers within one bit; ticks count 1..END.
    localparam logic [4:0] SMP_A_X16   = 5'd8;
    localparam logic [4:0] SMP_B_X16   = 5'd9;
    localparam logic [4:0] SMP_C_X16   = 5'd10;
    localparam logic [4:0] BIT_END_X16 = 5'd16;
    localparam logic [4:0] SMP_A_X8    = 5'd4;
    localparam logic [4:0] SMP_B_X8    = 5'd5;
    localparam logic [4:0] SMP_C_X8    = 5'd6;
    localparam logic [4:0] BIT_END_X8  = 5'd8;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       upe;
        logic       dor;
    } rx_entry_t;

    function automatic logic [3:0] char_bits(input logic [2:0] ucsz);
        case (ucsz)
            UCSZ_5:  return 4'd5;
            UCSZ_6:  return 4'd6;
            UCSZ_7:  return 4'd7;
            UCSZ_9:  return 4'd9;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/usart_baud_gen.sv
// Baud-rate divider: one tick every ubrr+1 cycles, restartable so a start edge aligns the sample grid.
module usart_baud_gen (
    input  logic        cp2,
    input  logic        ireset,
    input  logic        reload,
    input  logic [11:0] ubrr,
    output logic        tick
);

    logic [11:0] cnt;

    // >= rather than == so a divisor lowered below the running count still wraps promptly.
    assign tick = (cnt >= ubrr) && !reload;

    // NOTE: reset is synchronous; ireset is simply the highest-priority term inside the clocked block.
    always_ff @(posedge cp2) begin
        if (ireset || reload) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 12'd1;
        end
    end

endmodule

// File: rtl/usart_rx.sv
// USART receiver: synchroniser, start detect, majority-vote bit FSM and a small UDR receive FIFO.
module usart_rx
    import usart_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        cp2,
    input  logic        ireset,
    input  logic        rxd_i,
    input  logic        rxen,
    input  logic        u2x,
    input  logic [11:0] ubrr,
    input  logic [2:0]  ucsz,
    input  logic [1:0]  upm,
    input  logic        udr_rd,
    output logic [8:0]  rx_data,
    output logic        rxc,
    output logic        fe,
    output logic        upe,
    output logic        dor
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0] sync_q;
    logic       rxd_s;
    logic       rxd_prev;
    logic       start_edge;
    logic       tick;

    logic [2:0] state;
    logic [4:0] smp_cnt;
    logic [4:0] smp_n;
    logic [1:0] votes;
    logic [3:0] bit_idx;
    logic [8:0] shift;
    logic       cfg_u2x;
    logic [3:0] cfg_nbits;
    logic       cfg_par;
    logic       cfg_odd;
    logic       frame_upe;

    logic [4:0] smp_a, smp_b, smp_c, smp_end;
    logic       at_sample, decide, bit_end, bit_val;

    rx_entry_t  push_entry;
    logic       push_req;

    always_ff @(posedge cp2) begin
        if (ireset) begin
            sync_q   <= 2'b11;
            rxd_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[0], rxd_i};
            rxd_prev <= sync_q[1];
        end
    end

    assign rxd_s      = sync_q[1];
    assign start_edge = rxen && (state == ST_IDLE) && rxd_prev && !rxd_s;

    usart_baud_gen u_baud (
        .cp2    (cp2),
        .ireset (ireset),
        .reload (!rxen || start_edge),
        .ubrr   (ubrr),
        .tick   (tick)
    );

    assign smp_a   = cfg_u2x ? SMP_A_X8    : SMP_A_X16;
    assign smp_b   = cfg_u2x ? SMP_B_X8    : SMP_B_X16;
    assign smp_c   = cfg_u2x ? SMP_C_X8    : SMP_C_X16;
    assign smp_end = cfg_u2x ? BIT_END_X8  : BIT_END_X16;

    assign smp_n     = smp_cnt + 5'd1;
    assign at_sample = tick && (smp_n == smp_a || smp_n == smp_b);
    assign decide    = tick && (smp_n == smp_c) && (state != ST_IDLE);
    assign bit_end   = tick && (smp_n == smp_end);
    // Third vote is the live sample, so the decision lands on the same tick as sample C.
    assign bit_val   = (votes[1] & votes[0]) | (votes[1] & rxd_s) | (votes[0] & rxd_s);

    always_ff @(posedge cp2) begin
        if (ireset || !rxen) begin
            state     <= ST_IDLE;
            smp_cnt   <= '0;
            votes     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            cfg_u2x   <= 1'b0;
            cfg_nbits <= 4'd8;
            cfg_par   <= 1'b0;
            cfg_odd   <= 1'b0;
            frame_upe <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start_edge) begin
                state     <= ST_START;
                smp_cnt   <= '0;
                bit_idx   <= '0;
                shift     <= '0;
                frame_upe <= 1'b0;
                cfg_u2x   <= u2x;
                cfg_nbits <= char_bits(ucsz);
                cfg_par   <= upm[1];
                cfg_odd   <= upm[0];
            end
        end else begin
            if (tick) begin
                smp_cnt <= bit_end ? 5'd0 : smp_n;
            end
            if (at_sample) begin
                votes <= {votes[0], rxd_s};
            end
            case (state)
                ST_START: begin
                    if (decide && bit_val) begin
                        state <= ST_IDLE;
                    end else if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shift <= shift | (9'(bit_val) << bit_idx);
                    end
                    if (bit_end) begin
                        if (bit_idx == cfg_nbits - 4'd1) begin
                            bit_idx <= '0;
                            state   <= cfg_par ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        frame_upe <= bit_val != ((^shift) ^ cfg_odd);
                    end
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (decide) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rx_entry_t       mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            dor_pending;
    logic            full, do_push, do_pop;
    rx_entry_t       head;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push_req   = rxen && !ireset && (state == ST_STOP) && decide;
    assign push_entry = '{data: shift, fe: !bit_val, upe: frame_upe, dor: dor_pending};
    assign full       = (count == CW'(FIFO_DEPTH));
    assign do_push    = push_req && !full;
    assign do_pop     = udr_rd && rxc;

    always_ff @(posedge cp2) begin
        if (ireset || !rxen) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dor_pending <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A stored frame carries and clears the pending overrun; a discarded one raises it.
            if (push_req) dor_pending <= full;
        end
    end

    // NOTE: storage has no reset; every output field is gated by rxc so stale entries never show.
    always_ff @(posedge cp2) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign head    = mem[rd_ptr];
    assign rxc     = (count != '0);
    assign rx_data = rxc ? head.data : 9'd0;
    assign fe      = rxc & head.fe;
    assign upe     = rxc & head.upe;
    assign dor     = rxc ? head.dor : dor_pending;

endmodule

// File: tb/tb_usart_rx.sv
// Self-checking bench for usart_rx: directed frames plus randomized formats against a queue model.
module tb_usart_rx;

    localparam int DEPTH = 2;

    logic        cp2 = 1'b0;
    logic        ireset, rxd_i, rxen, u2x, udr_rd;
    logic [11:0] ubrr;
    logic [2:0]  ucsz;
    logic [1:0]  upm;
    logic [8:0]  rx_data;
    logic        rxc, fe, upe, dor;

    usart_rx #(.FIFO_DEPTH(DEPTH)) dut (
        .cp2(cp2), .ireset(ireset), .rxd_i(rxd_i), .rxen(rxen), .u2x(u2x),
        .ubrr(ubrr), .ucsz(ucsz), .upm(upm), .udr_rd(udr_rd),
        .rx_data(rx_data), .rxc(rxc), .fe(fe), .upe(upe), .dor(dor)
    );

    always #5 cp2 = ~cp2;

    typedef struct {
        logic [8:0] data;
        logic       fe;
        logic       upe;
        logic       dor;
    } exp_t;

    exp_t q[$];
    bit   dor_pend;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {rx_data, rxc, fe, upe, dor} for the head the model predicts.
    task automatic check_head(input string tag);
        logic [12:0] exp;
        if (q.size() == 0) exp = {9'd0, 1'b0, 1'b0, 1'b0, dor_pend};
        else               exp = {q[0].data, 1'b1, q[0].fe, q[0].upe, q[0].dor};
        check(tag, 32'({rx_data, rxc, fe, upe, dor}), 32'(exp));
    endtask

    function automatic int bits_of(input logic [2:0] code);
        case (code)
            3'b000:  return 5;
            3'b001:  return 6;
            3'b010:  return 7;
            3'b111:  return 9;
            default: return 8;
        endcase
    endfunction

    function automatic int bit_cycles();
        return (u2x ? 8 : 16) * (int'(ubrr) + 1);
    endfunction

    task automatic model_frame(input logic [8:0] d, input logic f, input logic p);
        if (q.size() < DEPTH) begin
            q.push_back('{data: d, fe: f, upe: p, dor: dor_pend});
            dor_pend = 1'b0;
        end else begin
            dor_pend = 1'b1;
        end
    endtask

    task automatic model_flush();
        q.delete();
        dor_pend = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        rxd_i = v;
        repeat (bit_cycles()) @(negedge cp2);
    endtask

    task automatic send_frame(input logic [8:0] data, input bit bad_par, input bit stop_bit,
                              input int gap_bits);
        int         n;
        logic [8:0] d;
        logic       par_en, pbit;
        n      = bits_of(ucsz);
        d      = data & 9'((1 << n) - 1);
        par_en = upm[1];
        pbit   = (^d) ^ upm[0] ^ bad_par;
        drive_bit(1'b0);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (par_en) drive_bit(pbit);
        drive_bit(stop_bit);
        model_frame(d, ~stop_bit, par_en & bad_par);
        for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
    endtask

    task automatic pop();
        @(negedge cp2) udr_rd = 1'b1;
        @(negedge cp2) udr_rd = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic set_cfg(input logic x2, input logic [11:0] div, input logic [2:0] sz,
                           input logic [1:0] pm);
        @(negedge cp2);
        u2x = x2; ubrr = div; ucsz = sz; upm = pm;
    endtask

    initial begin
        ireset = 1'b1; rxd_i = 1'b1; rxen = 1'b1; udr_rd = 1'b0;
        u2x = 1'b0; ubrr = 12'd0; ucsz = 3'b011; upm = 2'b00;
        dor_pend = 1'b0;
        repeat (3) @(negedge cp2);
        check_head("reset_state");
        ireset = 1'b0;
        repeat (4) @(negedge cp2);

        // Single 8N1 frame.
        send_frame(9'h065, 1'b0, 1'b1, 1);
        check("first_frame_data", 32'(rx_data), 32'h065);
        check_head("first_frame_head");
        pop();
        check_head("first_frame_popped");

        // Back-to-back frames, then one pop too many.
        send_frame(9'h065, 1'b0, 1'b1, 0);
        send_frame(9'h055, 1'b0, 1'b1, 1);
        check_head("b2b_head0");
        pop();
        check_head("b2b_head1");
        pop();
        check_head("b2b_empty");
        pop();
        check_head("b2b_pop_when_empty");

        // Overrun: third frame discarded, flag travels with the next stored frame.
        send_frame(9'h011, 1'b0, 1'b1, 1);
        send_frame(9'h022, 1'b0, 1'b1, 1);
        send_frame(9'h033, 1'b0, 1'b1, 1);
        check_head("ovr_full_head");
        pop();
        check_head("ovr_second");
        pop();
        check("ovr_dor_when_empty", 32'(dor), 32'(1));
        check_head("ovr_empty_pending");
        send_frame(9'h044, 1'b0, 1'b1, 1);
        send_frame(9'h045, 1'b0, 1'b1, 1);
        check_head("ovr_flag_entry");
        pop();
        check_head("ovr_clean_entry");
        pop();

        // 9E1 with bad parity and a low stop bit.
        set_cfg(1'b0, 12'd0, 3'b111, 2'b10);
        send_frame(9'h1A5, 1'b1, 1'b0, 2);
        check("9e1_flags", 32'({rx_data, upe, fe}), 32'({9'h1A5, 1'b1, 1'b1}));
        check_head("9e1_head");
        pop();

        // Short glitch must not start a frame; a clean frame follows.
        set_cfg(1'b0, 12'd0, 3'b011, 2'b00);
        rxd_i = 1'b0;
        repeat (3) @(negedge cp2);
        rxd_i = 1'b1;
        repeat (40) @(negedge cp2);
        check_head("glitch_no_push");
        send_frame(9'h05A, 1'b0, 1'b1, 1);
        check_head("after_glitch");
        pop();

        // Reset in the middle of a frame.
        send_frame(9'h077, 1'b0, 1'b1, 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        ireset = 1'b1;
        repeat (2) @(negedge cp2);
        rxd_i  = 1'b1;
        ireset = 1'b0;
        model_flush();
        repeat (40) @(negedge cp2);
        check_head("reset_mid_frame");
        send_frame(9'h03C, 1'b0, 1'b1, 1);
        check_head("after_reset_3c");
        pop();

        // rxen low in the middle of a frame with a full FIFO and pending overrun.
        send_frame(9'h0A1, 1'b0, 1'b1, 1);
        send_frame(9'h0A2, 1'b0, 1'b1, 1);
        send_frame(9'h0A3, 1'b0, 1'b1, 1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rxen = 1'b0;
        repeat (2) @(negedge cp2);
        rxd_i = 1'b1;
        model_flush();
        check_head("rxen_low_flush");
        repeat (20) @(negedge cp2);
        rxen = 1'b1;
        repeat (4) @(negedge cp2);
        send_frame(9'h03C, 1'b0, 1'b1, 1);
        check_head("after_rxen_3c");
        pop();

        // Randomized formats, divisors and error injection.
        for (int it = 0; it < 30; it++) begin
            logic [2:0] sz;
            int         pick;
            pick = $urandom_range(0, 5);
            case (pick)
                0: sz = 3'b000;
                1: sz = 3'b001;
                2: sz = 3'b010;
                3: sz = 3'b011;
                4: sz = 3'b111;
                default: sz = 3'b101;
            endcase
            set_cfg(1'($urandom_range(0, 1)), 12'($urandom_range(0, 2)), sz,
                    2'($urandom_range(0, 3)));
            send_frame(9'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       $urandom_range(1, 2));
            check_head($sformatf("rand%0d_head", it));
            for (int p = $urandom_range(0, 2); p > 0; p--) begin
                pop();
                check_head($sformatf("rand%0d_pop", it));
            end
        end
        while (q.size() > 0) begin
            pop();
            check_head("drain");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
